// File: rtl/load_use_stall_ctrl_pkg.sv
// Shared pipeline definitions for the stall controller: stall-state encoding and register constants.
package load_use_stall_ctrl_pkg;

    localparam int REG_ADDR_W_DEFAULT = 5;
    localparam logic [REG_ADDR_W_DEFAULT-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } stall_state_e;

endpackage

// File: rtl/load_use_stall_ctrl_lu_hazard_detect.sv
// Combinational load-use comparator: flags ID source operands produced by a load sitting in EX.
module lu_hazard_detect
    import load_use_stall_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  lu_rs,
    output logic                  lu_rt
);

    logic ex_load_src;

    // r0 and non-writing loads never produce a value worth waiting for
    assign ex_load_src = ex_mem_read & ex_reg_write & (ex_rd != REG_ADDR_W'(REG_ZERO));
    assign lu_rs       = ex_load_src & id_use_rs & (id_rs == ex_rd);
    assign lu_rt       = ex_load_src & id_use_rt & (id_rt == ex_rd);

endmodule

// File: rtl/load_use_stall_ctrl.sv
// Load-use / memory-wait stall controller for the 5-stage core.
// Optional stall counter enabled by defining STALL_CNT_EN.
module load_use_stall_ctrl
    import load_use_stall_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_hold,
    output logic                  ifid_hold,
    output logic                  idex_flush,
    output logic                  pipe_freeze,
    output logic                  hold_rs,
    output logic                  hold_rt,
    output logic [CNT_W-1:0]      stall_cycles
);

    stall_state_e state_q, state_d;
    logic lu_rs, lu_rt, lu, mem_stall;
    logic pc_hold_c, ifid_hold_c, idex_flush_c, pipe_freeze_c, hold_rs_c, hold_rt_c;

    lu_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_lu_hazard_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_rd        (ex_rd),
        .lu_rs        (lu_rs),
        .lu_rt        (lu_rt)
    );

    assign lu        = lu_rs | lu_rt;
    assign mem_stall = mem_req & ~mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory wait outranks load-use; LU_STALL never re-detects a hazard
    always_comb begin
        state_d       = state_q;
        pc_hold_c     = 1'b0;
        ifid_hold_c   = 1'b0;
        idex_flush_c  = 1'b0;
        pipe_freeze_c = 1'b0;
        hold_rs_c     = 1'b0;
        hold_rt_c     = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    pipe_freeze_c = 1'b1;
                    pc_hold_c     = 1'b1;
                    ifid_hold_c   = 1'b1;
                    state_d       = MEM_WAIT;
                end else if (lu) begin
                    pc_hold_c    = 1'b1;
                    ifid_hold_c  = 1'b1;
                    idex_flush_c = 1'b1;
                    hold_rs_c    = lu_rs;
                    hold_rt_c    = lu_rt;
                    state_d      = LU_STALL;
                end
            end
            LU_STALL: begin
                if (mem_stall) begin
                    pipe_freeze_c = 1'b1;
                    pc_hold_c     = 1'b1;
                    ifid_hold_c   = 1'b1;
                    state_d       = MEM_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    pipe_freeze_c = 1'b1;
                    pc_hold_c     = 1'b1;
                    ifid_hold_c   = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Reset overrides everything so no stale replay flag leaks out
    assign pc_hold     = pc_hold_c     & ~rst;
    assign ifid_hold   = ifid_hold_c   & ~rst;
    assign idex_flush  = idex_flush_c  & ~rst;
    assign pipe_freeze = pipe_freeze_c & ~rst;
    assign hold_rs     = hold_rs_c     & ~rst;
    assign hold_rt     = hold_rt_c     & ~rst;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pc_hold && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Self-checking bench for load_use_stall_ctrl: vector table plus hand sequences, scoreboard queue.
module tb_load_use_stall_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] id_rs, id_rt, ex_rd;
    logic          id_use_rs, id_use_rt, ex_mem_read, ex_reg_write, mem_req, mem_ready;
    logic          pc_hold, ifid_hold, idex_flush, pipe_freeze, hold_rs, hold_rt;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    load_use_stall_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_rd        (ex_rd),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .idex_flush   (idex_flush),
        .pipe_freeze  (pipe_freeze),
        .hold_rs      (hold_rs),
        .hold_rt      (hold_rt),
        .stall_cycles (stall_cycles)
    );

    // exp bit order: {pc_hold, ifid_hold, idex_flush, pipe_freeze, hold_rs, hold_rt}
    typedef struct {
        logic [AW-1:0] rs, rt;
        logic          use_rs, use_rt, mrd, rwr;
        logic [AW-1:0] rd;
        logic          mreq, mrdy;
        logic [5:0]    exp;
    } vec_t;

    typedef struct {
        logic [5:0]    outs;
        logic [CW-1:0] cnt;
        string         name;
    } exp_t;

    exp_t          sb[$];
    vec_t          tbl[15];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] cnt_model = '0;

    localparam logic [5:0] NONE   = 6'b000000;
    localparam logic [5:0] FREEZE = 6'b110100;

    function automatic vec_t mk(int rs, int rt, bit urs, bit urt, bit mrd, bit rwr, int rd,
                                bit mreq, bit mrdy, logic [5:0] exp);
        vec_t v;
        v.rs = AW'(rs); v.rt = AW'(rt); v.use_rs = urs; v.use_rt = urt;
        v.mrd = mrd; v.rwr = rwr; v.rd = AW'(rd); v.mreq = mreq; v.mrdy = mrdy; v.exp = exp;
        return v;
    endfunction

    function automatic logic [5:0] cur_outs();
        return {pc_hold, ifid_hold, idex_flush, pipe_freeze, hold_rs, hold_rt};
    endfunction

    function automatic logic [CW-1:0] cnt_exp();
`ifdef STALL_CNT_EN
        return cnt_model;
`else
        return '0;
`endif
    endfunction

    task automatic drive(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
        ex_mem_read = v.mrd; ex_reg_write = v.rwr; ex_rd = v.rd;
        mem_req = v.mreq; mem_ready = v.mrdy;
    endtask

    task automatic check_now(input string nm, input logic [5:0] e_outs, input logic [CW-1:0] e_cnt);
        checks++;
        if (cur_outs() !== e_outs) begin
            errors++;
            $display("FAIL %s outs got=%b want=%b", nm, cur_outs(), e_outs);
        end
        checks++;
        if (stall_cycles !== e_cnt) begin
            errors++;
            $display("FAIL %s stall_cycles got=%0d want=%0d", nm, stall_cycles, e_cnt);
        end
    endtask

    // One pipeline cycle: drive after the edge, push expectation, compare at the falling edge
    task automatic step(input vec_t v, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v);
        e.outs = v.exp; e.cnt = cnt_exp(); e.name = nm;
        sb.push_back(e);
        if (v.exp[5] && cnt_model != {CW{1'b1}}) cnt_model = cnt_model + 1'b1;
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            check_now(e.name, e.outs, e.cnt);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
        @(posedge clk);
        #2;
        rst = 1'b0;
        cnt_model = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
        tbl[0]  = mk(5, 3, 1, 0, 1, 1, 5, 0, 0, 6'b111010); // lw $5 -> use rs
        tbl[1]  = mk(5, 3, 1, 0, 1, 1, 5, 0, 0, NONE);      // LU_STALL suppresses
        tbl[2]  = mk(5, 3, 1, 0, 0, 1, 5, 0, 0, NONE);      // not a load
        tbl[3]  = mk(0, 0, 1, 0, 1, 1, 0, 0, 0, NONE);      // lw $0
        tbl[4]  = mk(7, 7, 1, 1, 1, 1, 7, 0, 0, 6'b111011); // both operands
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
        tbl[6]  = mk(4, 1, 1, 0, 1, 0, 4, 0, 0, NONE);      // load without reg write
        tbl[7]  = mk(9, 9, 0, 1, 1, 1, 9, 0, 0, 6'b111001); // rt only
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE);    // LU_STALL -> MEM_WAIT
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, NONE);      // ready: back to RUN
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, NONE);      // ready first cycle: no cost
        tbl[12] = mk(6, 2, 1, 0, 1, 1, 6, 1, 1, 6'b111010); // ready request + hazard
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
        tbl[14] = mk(5, 2, 0, 0, 1, 1, 5, 0, 0, NONE);      // rs not read

        #1;
        check_now("reset_hold", NONE, '0);
        drive(mk(5, 5, 1, 1, 1, 1, 5, 1, 0, NONE));
        #1;
        check_now("reset_forces_zero", NONE, '0);
        do_reset();

        for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Memory wait over a pending hazard, then hazard re-evaluated
        do_reset();
        for (int i = 0; i < 3; i++) step(mk(8, 0, 1, 0, 1, 1, 8, 1, 0, FREEZE), $sformatf("mw_freeze%0d", i));
        step(mk(8, 0, 1, 0, 1, 1, 8, 1, 1, NONE), "mw_ready");
        step(mk(8, 0, 1, 0, 1, 1, 8, 0, 0, 6'b111010), "mw_bubble");
        step(mk(8, 0, 1, 0, 1, 1, 8, 0, 0, NONE), "mw_after");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE), "mw_idle");

        // lw; lw dependent; use
        step(mk(2, 0, 1, 0, 1, 1, 2, 0, 0, 6'b111010), "b2b_first");
        step(mk(2, 0, 1, 0, 1, 1, 2, 0, 0, NONE), "b2b_stall");
        step(mk(0, 3, 0, 1, 1, 1, 3, 0, 0, 6'b111001), "b2b_second");
        step(mk(0, 3, 0, 1, 1, 1, 3, 0, 0, NONE), "b2b_stall2");

        // Async reset in the middle of MEM_WAIT
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE), "rst_enter");
        step(mk(11, 0, 1, 0, 1, 1, 11, 1, 0, FREEZE), "rst_wait");
        #2;
        rst = 1'b1;
        #1;
        check_now("rst_async", NONE, '0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
        @(posedge clk);
        #2;
        rst = 1'b0;
        cnt_model = '0;
        step(mk(11, 0, 1, 0, 1, 1, 11, 0, 0, 6'b111010), "rst_run_state");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE), "rst_idle");

        // Long wait drives the narrow counter into saturation
        do_reset();
        for (int i = 0; i < 20; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE), $sformatf("sat%0d", i));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, NONE), "sat_release");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE), "sat_hold");
`ifdef STALL_CNT_EN
        checks++;
        if (stall_cycles !== {CW{1'b1}}) begin
            errors++;
            $display("FAIL sat_final stall_cycles got=%0d want=%0d", stall_cycles, {CW{1'b1}});
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
